count_bcd_display: RTL and testbench

- Display-side consumer of the 7-bit 0–99 up/down counter value.
- Converts the counter's binary output to two BCD digits using a sequential double-dabble engine.
- Time-multiplexes the two digits onto a common-anode two-digit seven-segment display on the Spartan-6 board.
- Sits between the counter block and the board's segment/anode pins.

---
 rtl/count_bcd_display.sv | 156 +++++++++++++++
 tb/tb_count_bcd_display.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/count_bcd_display.sv
// Binary 0-99 count -> BCD via sequential double-dabble; drives a 2-digit common-anode 7-seg display.
// Latency: 8 clocks from capture edge to bcd_* update; seg follows one clock later.
// No backpressure: count_in changes while busy are ignored; optional LEADING_ZERO_BLANK_EN blanks tens 0.
module count_bcd_display #(
    parameter int SCAN_DIV = 50000,
    parameter int DIV_W    = 16
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic [6:0] count_in,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic [3:0] bcd_tens,
    output logic [3:0] bcd_ones,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [6:0]        last_sample;
    logic [14:0]       shift_reg;
    logic [14:0]       shift_adj;
    logic [14:0]       shift_nxt;
    logic [2:0]        iter;
    logic              oor;
    logic              start;
    logic              last_shift;
    logic              load_en;
    logic              shift_en;
    logic              commit_en;
    logic [DIV_W-1:0]  div_cnt;
    logic              tick;
    logic              digit_sel;
    logic [6:0]        seg_nxt;

    assign start      = (count_in != last_sample);
    assign last_shift = (iter == 3'd6);

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CONVERT;
            CONVERT: if (last_shift) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        load_en   = (state == IDLE) && start;
        shift_en  = (state == CONVERT);
        commit_en = (state == COMMIT);
    end

    // BCD nibbles live in [14:11] (tens) and [10:7] (ones); binary shifts out of [6:0].
    always_comb begin
        shift_adj = shift_reg;
        if (shift_reg[14:11] >= 4'd5) shift_adj[14:11] = shift_reg[14:11] + 4'd3;
        if (shift_reg[10:7]  >= 4'd5) shift_adj[10:7]  = shift_reg[10:7]  + 4'd3;
        shift_nxt = shift_adj << 1;
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            last_sample <= 7'd0;
            shift_reg   <= 15'd0;
            iter        <= 3'd0;
            oor         <= 1'b0;
            bcd_tens    <= 4'd0;
            bcd_ones    <= 4'd0;
        end else begin
            if (load_en) begin
                last_sample <= count_in;
                shift_reg   <= {8'd0, count_in};
                iter        <= 3'd0;
                oor         <= (count_in > 7'd99);
            end
            if (shift_en) begin
                shift_reg <= shift_nxt;
                iter      <= iter + 3'd1;
            end
            if (commit_en) begin
                bcd_tens <= oor ? 4'hF : shift_reg[14:11];
                bcd_ones <= oor ? 4'hF : shift_reg[10:7];
            end
        end
    end

    assign tick = (div_cnt == DIV_W'(SCAN_DIV - 1));

    // an is chosen from digit_sel before it toggles, so the first tick lights ones.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            div_cnt   <= '0;
            digit_sel <= 1'b0;
            an        <= 2'b11;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
            if (tick) begin
                digit_sel <= ~digit_sel;
                an        <= digit_sel ? 2'b01 : 2'b10;
            end
        end
    end

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            4'hF:    return 7'h3F;
            default: return 7'h7F;
        endcase
    endfunction

    always_comb begin
        seg_nxt = 7'h7F;
        case (an)
            2'b10: seg_nxt = seg_decode(bcd_ones);
            2'b01: begin
                seg_nxt = seg_decode(bcd_tens);
`ifdef LEADING_ZERO_BLANK_EN
                if (bcd_tens == 4'd0) seg_nxt = 7'h7F;
`endif
            end
            default: seg_nxt = 7'h7F;
        endcase
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            seg <= 7'h7F;
        end else begin
            seg <= seg_nxt;
        end
    end

endmodule

// File: tb/tb_count_bcd_display.sv
// Directed + random bench for count_bcd_display against an arithmetic model (n/10, n%10, digit table).
module tb_count_bcd_display;

    localparam int SD = 4;
    localparam logic [6:0] DIGITS [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                           7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    logic       Clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] count_in = 7'd0;
    logic [6:0] seg;
    logic [1:0] an;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_ones;
    logic       busy;

    int checks = 0;
    int failures = 0;
    int last = 0;

    always #5 Clk = ~Clk;

    count_bcd_display #(.SCAN_DIV(SD), .DIV_W(16)) dut (
        .Clk      (Clk),
        .reset    (reset),
        .count_in (count_in),
        .seg      (seg),
        .an       (an),
        .bcd_tens (bcd_tens),
        .bcd_ones (bcd_ones),
        .busy     (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] m_tens(input int n);
        return (n > 99) ? 4'hF : 4'(n / 10);
    endfunction

    function automatic logic [3:0] m_ones(input int n);
        return (n > 99) ? 4'hF : 4'(n % 10);
    endfunction

    function automatic logic [6:0] m_seg(input logic [3:0] d);
        if (d < 4'd10) return DIGITS[d];
        if (d == 4'hF) return 7'h3F;
        return 7'h7F;
    endfunction

    function automatic logic [6:0] m_tens_seg(input int n);
`ifdef LEADING_ZERO_BLANK_EN
        if (n < 10) return 7'h7F;
`endif
        return m_seg(m_tens(n));
    endfunction

    task automatic tick1();
        @(posedge Clk);
        #1;
    endtask

    // Drive v (DUT idle, v != last), then check busy window and commit at E8.
    task automatic run_conv(input int v);
        count_in = 7'(v);
        tick1();
        check("busy_e0", 32'(busy), 32'(1'b1));
        repeat (7) @(posedge Clk);
        #1;
        check("busy_e7", 32'(busy), 32'(1'b1));
        check("hold_tens_e7", 32'(bcd_tens), 32'(m_tens(last)));
        check("hold_ones_e7", 32'(bcd_ones), 32'(m_ones(last)));
        tick1();
        check("busy_e8", 32'(busy), 32'(1'b0));
        check("bcd_tens", 32'(bcd_tens), 32'(m_tens(v)));
        check("bcd_ones", 32'(bcd_ones), 32'(m_ones(v)));
        last = v;
    endtask

    task automatic check_display(input int n);
        int k;
        k = 0;
        while (an !== 2'b10 && k < 4 * SD) begin tick1(); k++; end
        check("an_ones_slot", 32'(an), 32'(2'b10));
        tick1();
        check("seg_ones", 32'(seg), 32'(m_seg(m_ones(n))));
        k = 0;
        while (an !== 2'b01 && k < 4 * SD) begin tick1(); k++; end
        check("an_tens_slot", 32'(an), 32'(2'b01));
        tick1();
        check("seg_tens", 32'(seg), 32'(m_tens_seg(n)));
    endtask

    initial begin
        int v;
        repeat (3) @(posedge Clk);
        #1;
        check("rst_seg", 32'(seg), 32'(7'h7F));
        check("rst_an", 32'(an), 32'(2'b11));
        check("rst_tens", 32'(bcd_tens), 32'd0);
        check("rst_ones", 32'(bcd_ones), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        @(negedge Clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick1();
            check("an_before_tick", 32'(an), 32'(2'b11));
            check("busy_idle_zero", 32'(busy), 32'd0);
        end
        tick1();
        check("an_first_tick", 32'(an), 32'(2'b10));
        tick1();
        check("seg_zero", 32'(seg), 32'(7'h40));

        run_conv(57);
        check_display(57);

        // Rapid changes: 99 captured, 0 skipped, 98 picked up after commit.
        count_in = 7'd99;
        tick1();
        check("rapid_busy_e0", 32'(busy), 32'd1);
        count_in = 7'd0;
        tick1();
        count_in = 7'd98;
        repeat (7) tick1();
        check("rapid_busy_e8", 32'(busy), 32'd0);
        check("rapid_tens_99", 32'(bcd_tens), 32'd9);
        check("rapid_ones_99", 32'(bcd_ones), 32'd9);
        tick1();
        check("rapid_busy_98", 32'(busy), 32'd1);
        repeat (8) tick1();
        check("rapid_tens_98", 32'(bcd_tens), 32'd9);
        check("rapid_ones_98", 32'(bcd_ones), 32'd8);
        last = 98;

        run_conv(120);
        check_display(120);

        // Reset at E4 of a conversion of 42.
        count_in = 7'd42;
        tick1();
        repeat (4) tick1();
        check("mid_busy_e4", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_tens", 32'(bcd_tens), 32'd0);
        check("mid_rst_ones", 32'(bcd_ones), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_seg", 32'(seg), 32'(7'h7F));
        check("mid_rst_an", 32'(an), 32'(2'b11));
        @(negedge Clk);
        reset = 1'b0;
        last = 0;
        run_conv(42);

        run_conv(7);
        check_display(7);

        for (int i = 0; i < 12; i++) begin
            v = int'($urandom_range(0, 127));
            if (v == last) v = (v + 1) % 128;
            run_conv(v);
            if (i % 3 == 0) check_display(v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
